// File: rtl/fme_window_feeder_pkg.sv
// Shared constants and sample type for the FME window feeder and the
// interpolation arithmetic it feeds.
package fme_pkg;

  localparam int FME_TAPS = 16;
  localparam int FME_DW   = 8;

  // Window samples carry 8 bits of headroom so the filter math can stay signed.
  function automatic int fme_sw(input int dw);
    return dw + 8;
  endfunction

  typedef logic signed [fme_sw(FME_DW)-1:0] fme_sample_t;

endpackage

// File: rtl/fme_window_feeder_if.sv
// Pixel-in / window-out handshake bundle of the FME window feeder.
// The slave modport is the feeder itself; the master modport is its environment.
interface fme_window_feeder_if
  import fme_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int ROW_LEN   = 64
);
  localparam int SW = fme_sw(DATAWIDTH);
  localparam int CW = $clog2(ROW_LEN);

  logic                   in_valid;
  logic                   in_ready;
  logic [DATAWIDTH-1:0]   in_data;
  logic                   in_last;
  logic                   win_valid;
  logic                   win_ready;
  logic [FME_TAPS*SW-1:0] win_data;
  logic [CW-1:0]          win_col;
  logic                   win_last;
  logic                   row_err;

  modport slave (
    input  in_valid, in_data, in_last, win_ready,
    output in_ready, win_valid, win_data, win_col, win_last, row_err
  );

  modport master (
    output in_valid, in_data, in_last, win_ready,
    input  in_ready, win_valid, win_data, win_col, win_last, row_err
  );

endinterface

// File: rtl/fme_window_feeder_tap_line.sv
// Sliding 16-tap line; o_taps is the window that results from shifting i_din in
// at A15, with A0 (oldest) in the low slice.
module fme_tap_line
  import fme_pkg::*;
#(
  parameter int SW = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_en,
  input  logic                   i_zero,
  input  logic [SW-1:0]          i_din,
  output logic [FME_TAPS*SW-1:0] o_taps
);

  localparam int HW = (FME_TAPS - 1) * SW;

  // The window is formed from the post-shift contents, so the sample that would
  // sit in A0 before a shift is always discarded; only 15 history taps are held.
  logic [HW-1:0]          r_hist;
  logic [FME_TAPS*SW-1:0] w_taps;

  assign w_taps = {i_din, r_hist};
  assign o_taps = w_taps;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= '0;
    end else if (i_zero) begin
      r_hist <= '0;
    end else if (i_en) begin
      r_hist <= w_taps[FME_TAPS*SW-1:SW];
    end
  end

endmodule

// File: rtl/fme_window_feeder.sv
// Streams pixels into a 16-sample sliding row window and presents one window per
// accepted pixel once 16 pixels of the current row have arrived.
module fme_window_feeder
  import fme_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int ROW_LEN   = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  fme_window_feeder_if.slave  bus
);

  localparam int SW = fme_sw(DATAWIDTH);
  localparam int WW = FME_TAPS * SW;
  localparam int CW = $clog2(ROW_LEN);
  localparam logic [CW-1:0] COL_MAX  = CW'(ROW_LEN - 1);
  localparam logic [CW-1:0] COL_FULL = CW'(FME_TAPS - 1);

  logic [CW-1:0] r_col;
  logic          r_win_valid;
  logic [WW-1:0] r_win_data;
  logic [CW-1:0] r_win_col;
  logic          r_win_last;
  logic          r_row_err;

  logic          w_in_ready;
  logic          w_accept;
  logic          w_col_end;
  logic          w_eor;
  logic          w_emit;
  logic          w_err;
  logic [SW-1:0] w_din;
  logic [WW-1:0] w_window;

  assign w_in_ready = !r_win_valid || bus.win_ready;
  assign w_accept   = bus.in_valid && w_in_ready && !clear;
  assign w_col_end  = (r_col == COL_MAX);
  assign w_eor      = w_col_end || bus.in_last;
  assign w_emit     = w_accept && (r_col >= COL_FULL);
  assign w_err      = w_accept && (bus.in_last != w_col_end);
  assign w_din      = {8'd0, bus.in_data};

  // End of row zeroes the line on the same edge the last window is captured.
  fme_tap_line #(.SW(SW)) u_tap_line (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_accept),
    .i_zero (clear || (w_accept && w_eor)),
    .i_din  (w_din),
    .o_taps (w_window)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
    end else if (clear) begin
      r_col <= '0;
    end else if (w_accept) begin
      r_col <= w_eor ? '0 : r_col + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_valid <= 1'b0;
      r_win_data  <= '0;
      r_win_col   <= '0;
      r_win_last  <= 1'b0;
      r_row_err   <= 1'b0;
    end else if (clear) begin
      r_win_valid <= 1'b0;
      r_win_data  <= '0;
      r_win_col   <= '0;
      r_win_last  <= 1'b0;
      r_row_err   <= 1'b0;
    end else begin
      r_row_err <= w_err;
      if (w_emit) begin
        r_win_valid <= 1'b1;
        r_win_data  <= w_window;
        r_win_col   <= r_col - COL_FULL;
        r_win_last  <= w_eor;
      end else if (bus.win_ready) begin
        r_win_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.win_valid = r_win_valid;
  assign bus.win_data  = r_win_data;
  assign bus.win_col   = r_win_col;
  assign bus.win_last  = r_win_last;
  assign bus.row_err   = r_row_err;

endmodule

// File: tb/tb_fme_window_feeder.sv
// Scoreboard bench for fme_window_feeder: a ROW_LEN=20 instance driven through
// directed and random traffic, plus a ROW_LEN=16 instance for the single-window row.
module tb_fme_window_feeder;
  import fme_pkg::*;

  localparam int RL = 20;
  localparam int SW = fme_sw(8);
  localparam int WW = FME_TAPS * SW;

  typedef struct {
    logic [WW-1:0] d;
    int            col;
    bit            last;
  } win_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;

  int   n_chk = 0;
  int   n_err = 0;

  win_t q[$];
  int   m_tap[FME_TAPS];
  int   m_col;
  bit   m_pend;
  bit   m_err;

  fme_window_feeder_if #(.DATAWIDTH(8), .ROW_LEN(RL)) bus20 ();
  fme_window_feeder_if #(.DATAWIDTH(8), .ROW_LEN(16)) bus16 ();

  fme_window_feeder #(.DATAWIDTH(8), .ROW_LEN(RL)) u_dut20 (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus20)
  );

  fme_window_feeder #(.DATAWIDTH(8), .ROW_LEN(16)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus16)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    foreach (m_tap[i]) m_tap[i] = 0;
    m_col  = 0;
    m_pend = 1'b0;
    m_err  = 1'b0;
  endtask

  // One clock of the ROW_LEN=20 instance: drive, check, then advance the model.
  task automatic step(input bit clr, input bit vld, input logic [7:0] d, input bit lst, input bit rdy);
    bit   acc, pop, eor;
    int   sh[FME_TAPS];
    win_t w;
    clear           = clr;
    bus20.in_valid  = vld;
    bus20.in_data   = d;
    bus20.in_last   = lst;
    bus20.win_ready = rdy;
    #1;
    chk("in_ready", WW'(bus20.in_ready), WW'(!m_pend || rdy));
    chk("win_valid", WW'(bus20.win_valid), WW'(m_pend));
    chk("row_err", WW'(bus20.row_err), WW'(m_err));
    if (m_pend && q.size() > 0) begin
      chk("win_data", bus20.win_data, q[0].d);
      chk("win_col", WW'(bus20.win_col), WW'(q[0].col));
      chk("win_last", WW'(bus20.win_last), WW'(q[0].last));
    end
    acc = !clr && vld && (!m_pend || rdy);
    pop = !clr && m_pend && rdy;
    @(posedge clk);
    if (clr) begin
      model_reset();
    end else begin
      if (pop) begin
        void'(q.pop_front());
        m_pend = 1'b0;
      end
      m_err = 1'b0;
      if (acc) begin
        for (int k = 0; k < FME_TAPS - 1; k++) sh[k] = m_tap[k+1];
        sh[FME_TAPS-1] = int'(d);
        eor   = lst || (m_col == RL - 1);
        m_err = lst != (m_col == RL - 1);
        if (m_col >= FME_TAPS - 1) begin
          w.d = '0;
          for (int k = 0; k < FME_TAPS; k++) w.d[k*SW +: SW] = SW'(sh[k]);
          w.col  = m_col - (FME_TAPS - 1);
          w.last = eor;
          q.push_back(w);
          m_pend = 1'b1;
        end
        for (int k = 0; k < FME_TAPS; k++) m_tap[k] = eor ? 0 : sh[k];
        m_col = eor ? 0 : m_col + 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic feed(input int n, input int base, input bit lastflag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 8'(base + i), lastflag && (i == n - 1), 1'b1);
  endtask

  initial begin
    logic [WW-1:0] e;
    fme_sample_t   s;
    bus20.in_valid = 1'b0; bus20.in_data = '0; bus20.in_last = 1'b0; bus20.win_ready = 1'b0;
    bus16.in_valid = 1'b0; bus16.in_data = '0; bus16.in_last = 1'b0; bus16.win_ready = 1'b0;
    model_reset();

    #12;
    chk("rst_win_valid", WW'(bus20.win_valid), '0);
    chk("rst_win_data", bus20.win_data, '0);
    chk("rst_win_col", WW'(bus20.win_col), '0);
    chk("rst_row_err", WW'(bus20.row_err), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-window row on the ROW_LEN=16 instance.
    for (int i = 1; i <= 16; i++) begin
      bus16.in_valid  = 1'b1;
      bus16.in_data   = 8'(i);
      bus16.in_last   = (i == 16);
      bus16.win_ready = 1'b1;
      #1;
      if (i == 16) chk("t1_pre_valid", WW'(bus16.win_valid), '0);
      @(negedge clk);
    end
    bus16.in_valid = 1'b0;
    bus16.in_last  = 1'b0;
    #1;
    e = '0;
    for (int k = 0; k < FME_TAPS; k++) e[k*SW +: SW] = SW'(k + 1);
    chk("t1_valid", WW'(bus16.win_valid), WW'(1));
    chk("t1_data", bus16.win_data, e);
    chk("t1_col", WW'(bus16.win_col), '0);
    chk("t1_last", WW'(bus16.win_last), WW'(1));
    chk("t1_row_err", WW'(bus16.row_err), '0);
    @(negedge clk);
    chk("t1_drain", WW'(bus16.win_valid), '0);

    // Two well-formed rows at full rate.
    feed(20, 0, 1'b1);
    feed(20, 0, 1'b1);
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);

    // Backpressure mid-row: the pending pixel is held until accepted.
    for (int i = 0; i < 20; i++) begin
      if (i == 17) repeat (5) step(1'b0, 1'b1, 8'(100 + i), 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'(100 + i), i == 19, 1'b1);
    end

    // Short row ending on pixel 18, then a normal row.
    feed(18, 40, 1'b1);
    feed(20, 60, 1'b1);
    // Missing in_last, a short row with no windows, a 16-pixel short row.
    feed(20, 80, 1'b0);
    feed(10, 7, 1'b1);
    feed(16, 0, 1'b1);

    // Clear mid-row, with a pixel offered in the same cycle.
    feed(17, 3, 1'b0);
    step(1'b1, 1'b1, 8'h55, 1'b0, 1'b1);
    feed(20, 9, 1'b1);

    repeat (200) step(1'b0, 1'($urandom % 2), 8'($urandom), ($urandom % 25) == 0, ($urandom % 4) != 0);

    // Full-scale pixels must read as positive samples.
    step(1'b1, 1'b0, 8'd0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1);
    #1;
    chk("t6_a15", WW'(bus20.win_data[15*SW +: SW]), WW'(16'h00FF));
    s = bus20.win_data[0 +: SW];
    chk("t6_positive", WW'(s > 0), WW'(1));
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);

    // Asynchronous reset while a window is pending.
    feed(17, 20, 1'b0);
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_win_valid", WW'(bus20.win_valid), '0);
    chk("t5_win_data", bus20.win_data, '0);
    chk("t5_win_col", WW'(bus20.win_col), '0);
    chk("t5_win_last", WW'(bus20.win_last), '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(i + 1), 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
